// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared mode encodings, occupancy states and lane-decode helpers
package decode_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Thermometer mask: lane pos is lit for every lane at or below idx.
    function automatic logic therm_bit(input int pos, input int idx);
        return pos <= idx;
    endfunction

    function automatic logic lane_bit(input logic mode, input int pos, input int idx);
        logic bit_val;
        bit_val = 1'b0;
        case (mode)
            MODE_ONEHOT: bit_val = (pos == idx);
            MODE_THERM:  bit_val = therm_bit(pos, idx);
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/onehot_encode_core.sv
// rtl/onehot_encode_core.sv - combinational index to one-hot/thermometer vector with range flag
module onehot_encode_core
    import decode_pkg::*;
#(
    parameter int IDX_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [IDX_W-1:0]   idx,
    input  logic               mode,
    output logic [NUM_OUT-1:0] vec,
    output logic               err
);

    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(NUM_OUT);

    // Out-of-range indices blank the whole vector instead of aliasing onto a lane.
    always_comb begin
        err = ({1'b0, idx} >= LIMIT);
        for (int i = 0; i < NUM_OUT; i++) begin
            vec[i] = !err && lane_bit(mode, i, int'(idx));
        end
    end

endmodule

// File: rtl/onehot_decode_pipe.sv
// rtl/onehot_decode_pipe.sv - registered index decoder with output register and optional skid entry
module onehot_decode_pipe
    import decode_pkg::*;
#(
    parameter int IDX_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_vec,
    output logic               out_err
);

    typedef struct packed {
        logic [NUM_OUT-1:0] vec;
        logic               err;
    } entry_t;

    occ_t               state;
    occ_t               state_nxt;
    entry_t             dec;
    entry_t             out_q;
    entry_t             skid_q;
    logic [NUM_OUT-1:0] dec_vec;
    logic               dec_err;
    logic               in_fire;
    logic               out_fire;
    logic               load_out_dec;
    logic               load_out_skid;
    logic               load_skid;

    onehot_encode_core #(
        .IDX_W   (IDX_W),
        .NUM_OUT (NUM_OUT)
    ) u_core (
        .idx  (in_idx),
        .mode (in_mode),
        .vec  (dec_vec),
        .err  (dec_err)
    );

    assign dec = '{vec: dec_vec, err: dec_err};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: if (in_fire) state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (in_fire && !out_fire) begin
                    state_nxt = OCC_FULL;
                end else if (!in_fire && out_fire) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL:  if (out_fire) state_nxt = OCC_ONE;
            default:   state_nxt = OCC_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != OCC_EMPTY);
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // A simultaneous in/out transfer reloads the output register directly, so no bubble.
    assign load_out_dec  = in_fire && ((state == OCC_EMPTY) || ((state == OCC_ONE) && out_fire));
    assign load_out_skid = out_fire && (state == OCC_FULL);
    assign load_skid     = (SKID != 0) && in_fire && (state == OCC_ONE) && !out_fire;

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nxt != OCC_FULL);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_dec) begin
                out_q <= dec;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign out_vec = out_q.vec;
    assign out_err = out_q.err;

endmodule

// File: tb/tb_onehot_decode_pipe.sv
// tb/tb_onehot_decode_pipe.sv - directed and random checks of two decoder configurations against a queue model
module tb_onehot_decode_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = 3'd0;
    logic       in_mode = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready8, out_valid8, out_err8;
    logic [7:0] out_vec8;
    logic       in_ready6, out_valid6, out_err6;
    logic [5:0] out_vec6;

    always #5 clk = ~clk;

    onehot_decode_pipe #(.IDX_W(3), .NUM_OUT(8), .SKID(1)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_idx(in_idx), .in_mode(in_mode),
        .out_valid(out_valid8), .out_ready(out_ready), .out_vec(out_vec8), .out_err(out_err8)
    );

    onehot_decode_pipe #(.IDX_W(3), .NUM_OUT(6), .SKID(0)) dut6 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready6), .in_idx(in_idx), .in_mode(in_mode),
        .out_valid(out_valid6), .out_ready(out_ready), .out_vec(out_vec6), .out_err(out_err6)
    );

    typedef struct {
        int idx;
        bit mode;
    } ent_t;

    ent_t        q8[$];
    ent_t        q6[$];
    logic [63:0] idle_vec8 = 64'd0;
    logic [63:0] idle_vec6 = 64'd0;
    logic        idle_err8 = 1'b0;
    logic        idle_err6 = 1'b0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [63:0] ref_vec(input int idx, input bit mode, input int n);
        if (idx >= n) return 64'd0;
        if (mode) return (64'd1 << (idx + 1)) - 64'd1;
        return 64'd1 << idx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input int idx, input bit m, input bit ordy, input bit fl, input bit r);
        bit   rdy8, rdy6;
        ent_t e;
        logic [31:0] idx_bits;
        @(negedge clk);
        idx_bits  = idx;
        in_valid  = v;
        in_idx    = idx_bits[2:0];
        in_mode   = m;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        rdy8 = (q8.size() < 2);
        rdy6 = (q6.size() == 0) || ordy;

        chk("in_ready8", 64'(in_ready8), 64'(rdy8));
        chk("out_valid8", 64'(out_valid8), 64'(q8.size() > 0));
        if (q8.size() > 0) begin
            chk("out_vec8", 64'(out_vec8), ref_vec(q8[0].idx, q8[0].mode, 8));
            chk("out_err8", 64'(out_err8), 64'(q8[0].idx >= 8));
        end else begin
            chk("idle_vec8", 64'(out_vec8), idle_vec8);
            chk("idle_err8", 64'(out_err8), 64'(idle_err8));
        end

        chk("in_ready6", 64'(in_ready6), 64'(rdy6));
        chk("out_valid6", 64'(out_valid6), 64'(q6.size() > 0));
        if (q6.size() > 0) begin
            chk("out_vec6", 64'(out_vec6), ref_vec(q6[0].idx, q6[0].mode, 6));
            chk("out_err6", 64'(out_err6), 64'(q6[0].idx >= 6));
        end else begin
            chk("idle_vec6", 64'(out_vec6), idle_vec6);
            chk("idle_err6", 64'(out_err6), 64'(idle_err6));
        end

        e.idx  = idx;
        e.mode = m;
        if (r || fl) begin
            q8.delete();
            q6.delete();
            idle_vec8 = 64'd0;
            idle_vec6 = 64'd0;
            idle_err8 = 1'b0;
            idle_err6 = 1'b0;
        end else begin
            if (q8.size() > 0 && ordy) begin
                idle_vec8 = ref_vec(q8[0].idx, q8[0].mode, 8);
                idle_err8 = (q8[0].idx >= 8);
                void'(q8.pop_front());
            end
            if (v && rdy8) q8.push_back(e);
            if (q6.size() > 0 && ordy) begin
                idle_vec6 = ref_vec(q6[0].idx, q6[0].mode, 6);
                idle_err6 = (q6[0].idx >= 6);
                void'(q6.pop_front());
            end
            if (v && rdy6) q6.push_back(e);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // reset state, then single one-hot code
        cyc(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // thermometer and out-of-range for the narrow instance
        cyc(1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // stall with two pushes, then release
        cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // back-to-back sweep
        for (int i = 0; i < 8; i++) cyc(1'b1, i, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // fill, then flush with a code offered
        cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset mid-stall, then one fresh code
        cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // random traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 4) != 0, int'($urandom % 8), 1'($urandom % 2),
                ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 97) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
